// File: rtl/event_debounce_pulse.sv
// event_debounce_pulse: synchronise, debounce and edge-detect a raw event line.
// CLK/RST(async, low) | enable_i, event_i -> increment_o, level_o, busy_o
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active-low
//   enable_i     1 = pulses allowed; 0 = increment_o held 0, debouncer keeps running
//   event_i      raw asynchronous event input, active-high
//   increment_o  one-cycle pulse per qualified edge (to the counter's increment_i)
//   level_o      debounced level of event_i
//   busy_o       1 while a rising or falling edge is being qualified
//
// Optional feature macro: EVENT_BOTH_EDGES_EN
//   When defined, a qualified falling edge also emits an increment_o pulse.
module event_debounce_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DBC_WIDTH       = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable_i,
  input  logic event_i,
  output logic increment_o,
  output logic level_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  localparam logic [DBC_WIDTH-1:0] DBC_LAST =
    DBC_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_s;

  state_t                 state_q;
  logic [DBC_WIDTH-1:0]   dbc_q;
  logic                   level_q;
  logic                   inc_q;

  // Stage 0 takes the raw line; the last stage feeds the FSM.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], event_i};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_LOW;
      dbc_q   <= '0;
      level_q <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      // Pulse lasts one cycle unless a transition below sets it.
      inc_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (sync_s) begin
            state_q <= S_RISE_CHK;
            dbc_q   <= '0;
          end
        end
        S_RISE_CHK: begin
          if (!sync_s) begin
            state_q <= S_LOW;
          end else if (dbc_q == DBC_LAST) begin
            state_q <= S_HIGH;
            level_q <= 1'b1;
            inc_q   <= enable_i;
          end else begin
            dbc_q <= dbc_q + DBC_WIDTH'(1);
          end
        end
        S_HIGH: begin
          if (!sync_s) begin
            state_q <= S_FALL_CHK;
            dbc_q   <= '0;
          end
        end
        S_FALL_CHK: begin
          if (sync_s) begin
            state_q <= S_HIGH;
          end else if (dbc_q == DBC_LAST) begin
            state_q <= S_LOW;
            level_q <= 1'b0;
`ifdef EVENT_BOTH_EDGES_EN
            inc_q   <= enable_i;
`else
            inc_q   <= 1'b0;
`endif
          end else begin
            dbc_q <= dbc_q + DBC_WIDTH'(1);
          end
        end
        default: begin
          state_q <= S_LOW;
          dbc_q   <= '0;
        end
      endcase
    end
  end

  assign increment_o = inc_q;
  assign level_o     = level_q;
  assign busy_o      = (state_q == S_RISE_CHK) ||
                       (state_q == S_FALL_CHK);

endmodule

// File: tb/tb_event_debounce_pulse.sv
// tb_event_debounce_pulse: directed bench for event_debounce_pulse.
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4; pulses tallied by a sampling monitor.
module tb_event_debounce_pulse;

  logic CLK = 1'b0;
  logic RST;
  logic enable_i;
  logic event_i;
  logic increment_o;
  logic level_o;
  logic busy_o;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int wide   = 0;
  logic inc_prev = 1'b0;
  int base;
  int exp_pairs;

  event_debounce_pulse #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .DBC_WIDTH      (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable_i   (enable_i),
    .event_i    (event_i),
    .increment_o(increment_o),
    .level_o    (level_o),
    .busy_o     (busy_o)
  );

  always #5 CLK = ~CLK;

  // Downstream counter model: one count per cycle increment_o is high.
  always @(posedge CLK) begin
    #1;
    if (RST === 1'b1) begin
      if (increment_o === 1'b1) pulses++;
      if (increment_o === 1'b1 && inc_prev === 1'b1) wide++;
      inc_prev = increment_o;
    end else begin
      inc_prev = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  initial begin
    RST      = 1'b0;
    enable_i = 1'b1;
    event_i  = 1'b0;
    #2;
    chk("rst_inc",   {31'd0, increment_o}, 32'd0);
    chk("rst_level", {31'd0, level_o},     32'd0);
    chk("rst_busy",  {31'd0, busy_o},      32'd0);

    // 1: event high through reset release, edge 1 is next posedge
    @(negedge CLK);
    RST     = 1'b1;
    event_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("t1_inc_e%0d", k),
          {31'd0, increment_o}, (k == 7) ? 32'd1 : 32'd0);
      if (k == 3) chk("t1_busy_e3", {31'd0, busy_o}, 32'd1);
    end
    chk("t1_level", {31'd0, level_o}, 32'd1);
    chk("t1_busy_hi", {31'd0, busy_o}, 32'd0);
    base = pulses;
    event_i = 1'b0;
    step(10);
    chk("t1_fall_level", {31'd0, level_o}, 32'd0);
`ifdef EVENT_BOTH_EDGES_EN
    chk("t1_fall_pulses", pulses - base, 32'd1);
`else
    chk("t1_fall_pulses", pulses - base, 32'd0);
`endif

    // 2: four-sample high is rejected, busy for four cycles
    base = pulses;
    event_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 4) event_i = 1'b0;
      chk($sformatf("t2_busy_e%0d", k), {31'd0, busy_o},
          (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("t2_level_e%0d", k), {31'd0, level_o}, 32'd0);
    end
    chk("t2_pulses", pulses - base, 32'd0);

    // 3: enable low, level follows but no pulses
    base = pulses;
    enable_i = 1'b0;
    event_i  = 1'b1;
    step(10);
    chk("t3_level_hi", {31'd0, level_o}, 32'd1);
    event_i = 1'b0;
    step(10);
    chk("t3_level_lo", {31'd0, level_o}, 32'd0);
    chk("t3_pulses", pulses - base, 32'd0);
    enable_i = 1'b1;

    // 4: ten clean 12-cycle press/release pairs
    base = pulses;
    wide = 0;
    repeat (10) begin
      event_i = 1'b1;
      step(6);
      event_i = 1'b0;
      step(6);
    end
    step(10);
`ifdef EVENT_BOTH_EDGES_EN
    exp_pairs = 20;
`else
    exp_pairs = 10;
`endif
    chk("t4_counter", pulses - base, exp_pairs);
    chk("t4_no_wide", wide, 32'd0);

    // 5: reset aborts an in-progress rise
    base = pulses;
    event_i = 1'b1;
    step(4);
    chk("t5_busy_pre", {31'd0, busy_o}, 32'd1);
    RST     = 1'b0;
    event_i = 1'b0;
    #1;
    chk("t5_rst_inc",   {31'd0, increment_o}, 32'd0);
    chk("t5_rst_level", {31'd0, level_o},     32'd0);
    chk("t5_rst_busy",  {31'd0, busy_o},      32'd0);
    @(negedge CLK);
    RST = 1'b1;
    step(10);
    chk("t5_pulses", pulses - base, 32'd0);
    chk("t5_level",  {31'd0, level_o}, 32'd0);

    // 6: three-sample low glitch while high
    base = pulses;
    event_i = 1'b1;
    step(8);
    chk("t6_rise_pulse", pulses - base, 32'd1);
    base = pulses;
    event_i = 1'b0;
    step(3);
    event_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("t6_level_c%0d", k), {31'd0, level_o}, 32'd1);
    end
    chk("t6_glitch_pulses", pulses - base, 32'd0);
    event_i = 1'b0;
    step(10);
    chk("t6_level_end", {31'd0, level_o}, 32'd0);
    chk("t6_no_wide", wide, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
